// File: rtl/spike_packetizer_if.sv
// Packet send channel between the spike packetizer and the router's
// local injection port. An all-zero packet means "nothing offered".
interface spike_packetizer_if;
  logic [33:0] send_packet;
  logic        send_ready;

  modport master (output send_packet, input  send_ready);
  modport slave  (input  send_packet, output send_ready);
endinterface

// File: rtl/spike_packetizer.sv
// Per-core spike transmitter: latches the spike vector on a tick and emits
// one 34-bit destination packet per fired neuron, lowest neuron index first.
module spike_packetizer #(
  parameter int NUM_NEURONS = 256,
  parameter int AXON_W      = 8,
  parameter int DELAY_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [NUM_NEURONS-1:0]         spikes,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_addr,
  input  logic [2+AXON_W+DELAY_W-1:0]    cfg_data,
  spike_packetizer_if.master             send,
  output logic                           busy,
  output logic                           done,
  output logic                           tick_dropped
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CFG_W = 2 + AXON_W + DELAY_W;
  localparam int PAD_W = 34 - 1 - CFG_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_r;
  logic [1:0]             state_nx_s;
  logic [NUM_NEURONS-1:0] pending_r;
  logic [NUM_NEURONS-1:0] pending_nx_s;
  logic [NUM_NEURONS-1:0] sel_onehot_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [33:0]            send_packet_r;
  logic [33:0]            packet_nx_s;
  logic                   slot_free_s;
  logic                   busy_r;
  logic                   done_r;
  logic                   tick_dropped_r;
  logic [CFG_W-1:0]       table_r [NUM_NEURONS];

  // The table entry is already laid out {core, axon, delay}, matching bits [32:19].
  function automatic logic [33:0] build_packet(input logic [CFG_W-1:0] entry);
    build_packet = {1'b1, entry, {PAD_W{1'b0}}};
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] vec);
    lowest_set = {IDX_W{1'b0}};
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lowest_set = IDX_W'(i);
      end else begin
        lowest_set = lowest_set;
      end
    end
  endfunction

  assign sel_onehot_s = pending_r & (~pending_r + NUM_NEURONS'(1));
  assign sel_idx_s    = lowest_set(pending_r);
  assign slot_free_s  = (send_packet_r == 34'd0) || send.send_ready;

  // Next-state, pending-vector and packet-slot selection.
  always_comb begin
    state_nx_s   = state_r;
    pending_nx_s = pending_r;
    packet_nx_s  = send_packet_r;
    case (state_r)
      IDLE: begin
        if (tick) begin
          pending_nx_s = spikes;
          state_nx_s   = SCAN;
        end else begin
          state_nx_s   = IDLE;
        end
      end
      SCAN: begin
        if (slot_free_s) begin
          if (pending_r != {NUM_NEURONS{1'b0}}) begin
            packet_nx_s  = build_packet(table_r[sel_idx_s]);
            pending_nx_s = pending_r & ~sel_onehot_s;
          end else begin
            packet_nx_s  = 34'd0;
            state_nx_s   = DONE;
          end
        end else begin
          packet_nx_s  = send_packet_r;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s   = IDLE;
        pending_nx_s = {NUM_NEURONS{1'b0}};
        packet_nx_s  = 34'd0;
      end
    endcase
  end

  // Control state, pending spikes and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      pending_r      <= {NUM_NEURONS{1'b0}};
      send_packet_r  <= 34'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      tick_dropped_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      pending_r      <= pending_nx_s;
      send_packet_r  <= packet_nx_s;
      busy_r         <= (state_nx_s != IDLE);
      done_r         <= (state_nx_s == DONE);
      tick_dropped_r <= tick && (state_r != IDLE);
    end
  end

  // Destination table; writes only land while idle so a scan sees a stable table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        table_r[i] <= {CFG_W{1'b0}};
      end
    end else if (cfg_we && (state_r == IDLE)) begin
      table_r[cfg_addr] <= cfg_data;
    end else begin
      table_r <= table_r;
    end
  end

  assign send.send_packet = send_packet_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign tick_dropped     = tick_dropped_r;

endmodule

// File: tb/tb_spike_packetizer.sv
// Self-checking bench for spike_packetizer: a queue-based transmission model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_spike_packetizer;

  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] spikes = '0;
  logic         cfg_we = 1'b0;
  logic [7:0]   cfg_addr = 8'd0;
  logic [13:0]  cfg_data = 14'd0;
  logic         busy, done, tick_dropped;

  spike_packetizer_if sif ();

  spike_packetizer #(.NUM_NEURONS(N), .AXON_W(8), .DELAY_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .spikes(spikes),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .send(sif), .busy(busy), .done(done), .tick_dropped(tick_dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: phase 0 idle, 1 scan started, 2 packet shown, 3 done.
  int          m_phase;
  logic [33:0] m_q[$];
  logic [33:0] m_shown;
  logic        m_drop;
  logic [13:0] m_table [N];

  function automatic logic [33:0] pk(input logic [1:0] core, input logic [7:0] axon,
                                     input logic [3:0] delay);
    logic [33:0] p;
    p = 34'd0;
    p = p + (34'd1 << 33) + ({32'd0, core} << 31) + ({26'd0, axon} << 23) + ({30'd0, delay} << 19);
    return p;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_shown = 34'd0;
    m_drop  = 1'b0;
    for (int i = 0; i < N; i++) m_table[i] = 14'd0;
  endtask

  task automatic model_step();
    bit was_idle;
    was_idle = (m_phase == 0);
    m_drop   = tick && !was_idle;
    if (was_idle && cfg_we) m_table[cfg_addr] = cfg_data;
    case (m_phase)
      0: if (tick) begin
        m_q.delete();
        for (int i = 0; i < N; i++)
          if (spikes[i]) m_q.push_back(pk(m_table[i][13:12], m_table[i][11:4], m_table[i][3:0]));
        m_phase = 1;
      end
      1: if (m_q.size() == 0) m_phase = 3;
         else begin m_shown = m_q.pop_front(); m_phase = 2; end
      2: if (sif.send_ready) begin
        if (m_q.size() != 0) m_shown = m_q.pop_front();
        else begin m_shown = 34'd0; m_phase = 3; end
      end
      3: m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_packet", sif.send_packet, m_shown);
        check("model_busy", {33'd0, busy}, {33'd0, m_phase != 0});
        check("model_done", {33'd0, done}, {33'd0, m_phase == 3});
        check("model_drop", {33'd0, tick_dropped}, {33'd0, m_drop});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int addr, input logic [13:0] data);
    cfg_we = 1'b1; cfg_addr = addr[7:0]; cfg_data = data;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_phase != 0 && k < 600) begin cyc(1); k++; end
    n_cmp++;
    if (m_phase != 0) begin
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", k);
    end
  endtask

  // Drives spikes and a one-cycle tick; returns at the negedge after the tick edge.
  task automatic fire(input logic [N-1:0] sp);
    spikes = sp; tick = 1'b1;
    cyc(1);
    tick = 1'b0; spikes = '0;
  endtask

  logic [33:0] p3, p64, p200, p200_new;
  logic [N-1:0] three;
  int done_cnt, busy_cnt;

  initial begin
    sif.send_ready = 1'b1;
    cyc(2);
    check("reset_packet", sif.send_packet, 34'd0);
    check("reset_busy", {33'd0, busy}, 34'd0);
    check("reset_done", {33'd0, done}, 34'd0);
    rst = 1'b1;
    cmp_en = 1'b1;
    cyc(1);

    // Zero spikes: busy two cycles, done once on the second.
    fire('0);
    done_cnt = 0; busy_cnt = 0;
    check("zero_done_first", {33'd0, done}, 34'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) check("zero_done_at_n1", {33'd0, done}, 34'd1);
      done_cnt += int'(done); busy_cnt += int'(busy);
      check("zero_pkt", sif.send_packet, 34'd0);
      cyc(1);
    end
    check("zero_done_cnt", 34'(done_cnt), 34'd1);
    check("zero_busy_cnt", 34'(busy_cnt), 34'd2);

    // Single spike on neuron 5.
    cfg(5, {2'd2, 8'h11, 4'd3});
    fire(N'(1) << 5);
    check("single_n0", sif.send_packet, 34'd0);
    cyc(1);
    check("single_pkt", sif.send_packet, 34'h3_0898_0000);
    cyc(1);
    check("single_cleared", sif.send_packet, 34'd0);
    check("single_done", {33'd0, done}, 34'd1);
    cyc(1);
    check("single_idle", {33'd0, busy}, 34'd0);

    // Three spikes, ascending order, back to back.
    p3 = pk(2'd1, 8'h33, 4'd1); p64 = pk(2'd0, 8'h40, 4'd7); p200 = pk(2'd3, 8'hC8, 4'd15);
    p200_new = pk(2'd2, 8'h5A, 4'd2);
    cfg(3, {2'd1, 8'h33, 4'd1});
    cfg(64, {2'd0, 8'h40, 4'd7});
    cfg(200, {2'd3, 8'hC8, 4'd15});
    three = (N'(1) << 200) | (N'(1) << 3) | (N'(1) << 64);
    fire(three);
    cyc(1); check("order_0", sif.send_packet, p3);
    cyc(1); check("order_1", sif.send_packet, p64);
    cyc(1); check("order_2", sif.send_packet, p200);
    cyc(1); check("order_done", {33'd0, done}, 34'd1);
    wait_idle();

    // Backpressure on neuron 64's packet.
    fire(three);
    cyc(2); check("stall_pre", sif.send_packet, p64);
    sif.send_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1); check("stall_hold", sif.send_packet, p64);
    end
    sif.send_ready = 1'b1;
    cyc(1); check("stall_next", sif.send_packet, p200);
    cyc(1); check("stall_done", {33'd0, done}, 34'd1);
    wait_idle();

    // Tick and table write while busy are both ignored.
    fire(three);
    tick = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd200; cfg_data = {2'd2, 8'h5A, 4'd2};
    cyc(1);
    tick = 1'b0; cfg_we = 1'b0;
    check("drop_pulse", {33'd0, tick_dropped}, 34'd1);
    check("drop_scan_kept", sif.send_packet, p3);
    cyc(1);
    check("drop_single", {33'd0, tick_dropped}, 34'd0);
    wait_idle();
    fire(N'(1) << 200);
    cyc(1);
    check("table_kept", sif.send_packet, p200);
    wait_idle();

    // Same-cycle table write and tick: the scan sees the new entry.
    cfg_we = 1'b1; cfg_addr = 8'd200; cfg_data = {2'd2, 8'h5A, 4'd2};
    fire(N'(1) << 200);
    cfg_we = 1'b0;
    cyc(1);
    check("same_cycle_cfg", sif.send_packet, p200_new);
    wait_idle();

    // Reset mid-scan after the first of three packets.
    fire(three);
    cyc(2);
    #2 rst = 1'b0;
    #1;
    check("rst_packet", sif.send_packet, 34'd0);
    check("rst_busy", {33'd0, busy}, 34'd0);
    check("rst_done", {33'd0, done}, 34'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("rst_stays_idle", {33'd0, busy}, 34'd0);
    fire(N'(1) << 7);
    cyc(1);
    check("rst_fresh_pkt", sif.send_packet, 34'h2_0000_0000);
    cyc(1);
    check("rst_no_stale", sif.send_packet, 34'd0);
    wait_idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] sp;
      for (int w = 0; w < N / 32; w++) begin
        sp[w*32 +: 32] = $urandom() & $urandom() & $urandom();
      end
      spikes = sp;
      tick = ($urandom_range(0, 24) == 0);
      sif.send_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_addr = 8'($urandom_range(0, 255));
      cfg_data = 14'($urandom());
      cyc(1);
    end
    tick = 1'b0; cfg_we = 1'b0; sif.send_ready = 1'b1;
    wait_idle();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spike_packetizer.md
# spike_packetizer

Per-core spike transmitter that turns the spike vector produced at each timestep tick into a serial stream of 34-bit spike packets for the router's local injection input. Each fired neuron is looked up in an internal destination table (core, axon, delay), and one packet per cycle is emitted in ascending neuron order. It sits between the core's neuron update stage and the router, and is the sending end of the router packet format.

## Interface

Parameters:
- NUM_NEURONS, 256, neurons per core; spike vector width and table depth
- AXON_W, 8, destination axon index width
- DELAY_W, 4, axonal delay field width

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  timestep strobe; samples spikes when idle
- spikes  in  NUM_NEURONS  fired-neuron vector, bit i = neuron i
- cfg_we  in  1  destination table write enable
- cfg_addr  in  $clog2(NUM_NEURONS)  table entry index
- cfg_data  in  2+AXON_W+DELAY_W  {dest_core[1:0], axon, delay}
- send_ready  in  1  downstream accepts current packet this cycle
- send_packet  out  34  packet; all-zero = no packet
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse, timestep fully transmitted
- tick_dropped  out  1  one-cycle pulse, tick ignored while busy

## Operation

- Packet format: [33] = 1 (keeps valid packets non-zero), [32:31] = dest_core, [30:23] = axon, [22:19] = delay, [18:0] = 0.
- Destination table: NUM_NEURONS entries. Writes are accepted only in IDLE. cfg_we while busy is ignored.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on tick, latch spikes into a pending register and go to SCAN. tick_dropped stays low.
  - SCAN: an output slot is free when send_packet is zero or send_ready is high. When the slot is free and pending is non-zero:
    - select the lowest set pending bit i;
    - load the packet built from table[i] into the send_packet register;
    - clear pending bit i.
  - SCAN: when the slot is free and pending is zero, clear send_packet and go to DONE.
  - SCAN: when send_packet is non-zero and send_ready is low, hold send_packet and pending unchanged.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- A transfer occurs in any cycle where send_packet is non-zero and send_ready is high.
- tick in SCAN or DONE: pulse tick_dropped the next cycle. The tick is discarded and the in-flight scan is unaffected.
- Loopback is legal: dest_core may equal the local core id. Delivery back to this core is the router's job.
- Duplicate table entries are legal; no checking is done.

## Timing

- Reset values: send_packet = 0, busy = 0, done = 0, tick_dropped = 0, FSM = IDLE, pending = 0, all table entries = 0.
- Reset asserted mid-scan: all state above clears immediately (asynchronously). Untransmitted spikes are lost.
- Tick sampled at edge N:
  - SCAN and busy are visible after edge N.
  - The first packet is visible after edge N+1, giving 2-edge latency.
- Throughput: one packet per cycle while send_ready is held high.
- K spikes with send_ready constantly high:
  - packets occupy cycles after edges N+1 through N+K;
  - the last packet is accepted at edge N+K+1, and the DONE state holds after that edge;
  - done is high for the cycle after edge N+K+1;
  - IDLE and busy = 0 hold after edge N+K+2.
- Zero spikes: DONE after edge N+1, done high for that single cycle, IDLE after edge N+2.
- send_ready low on a valid packet: packet is bit-identical until the accepting edge. Ordering is never altered.
- tick and cfg_we in the same IDLE cycle: the table write completes at that edge. The scan reads the updated entry, because table reads begin at edge N+1.
- The spikes input is ignored except at the accepting tick edge.

## Test plan

- Reset, then tick with spikes = 0 -> send_packet stays 0; done high exactly one cycle, 2 edges after tick; busy high for 2 cycles.
- table[5] = {core 2, axon 0x11, delay 3}, spikes bit 5 only, send_ready = 1 -> single packet 0x3_0898_0000, visible 2 edges after tick; done pulse the cycle after it is accepted.
- spikes bits {200, 3, 64}, distinct table entries -> three packets on consecutive cycles, in order 3, 64, 200; no gaps; then done.
- Same as above with send_ready low for 4 cycles while packet for neuron 64 is shown -> packet holds for 4 cycles; neuron 200 follows the cycle after send_ready returns high; no packet lost or duplicated.
- tick again while in SCAN, plus a cfg_we to entry 200 while busy -> tick_dropped pulses one cycle; the current scan is unchanged; entry 200 keeps its old value (read back via a later scan).
- rst low mid-scan after 1 of 3 packets -> all outputs 0 immediately; after release, a new tick transmits normally and no stale spikes appear.
